pipe_ctrl_unit: RTL and testbench

Pipelined control unit for the 5-stage MIPS core: decodes the ID-stage opcode into a control bundle and carries it through ID/EX, EX/MEM and MEM/WB stage registers. It also owns hazard control: load-use stall, jump redirect with IF/ID flush, taken-branch flush and external freeze. It flags illegal opcodes, which are decoded as bubbles, and counts them in a saturating counter. It sits beside the datapath pipeline registers and replaces the purely combinational decoder.

---
 rtl/pipe_ctrl_pkg.sv | 51 +++++
 rtl/pipe_ctrl_unit_decode.sv | 85 ++++++++
 rtl/pipe_ctrl_unit.sv | 148 ++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode, ALU-op and control-bundle definitions for the pipelined
// MIPS control unit.
package pipe_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_OR    = 2'b11;

   typedef struct packed {
      logic       reg_dst;
      logic       alu_src;
      logic [1:0] alu_op;
      logic       branch;
      logic       jump;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic       link;
   } ctrl_t;

   // Later stages only carry the fields they still consume.
   typedef struct packed {
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
      logic reg_write;
      logic link;
   } mem_ctrl_t;

   typedef struct packed {
      logic mem_to_reg;
      logic reg_write;
      logic link;
   } wb_ctrl_t;

   localparam ctrl_t     CTRL_BUBBLE = '0;
   localparam mem_ctrl_t MEM_BUBBLE  = '0;
   localparam wb_ctrl_t  WB_BUBBLE   = '0;

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational ID-stage decoder: opcode to control bundle, destination
// register, source-use flags and illegal-opcode flag.
module ctrl_decode
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic              valid,
   input  logic [5:0]        opcode,
   input  logic [REG_AW-1:0] rt,
   input  logic [REG_AW-1:0] rd,
   output ctrl_t             ctrl,
   output logic [REG_AW-1:0] wr_reg,
   output logic              rs_use,
   output logic              rt_use,
   output logic              illegal
);

   always_comb begin
      ctrl    = CTRL_BUBBLE;
      wr_reg  = '0;
      rs_use  = 1'b0;
      rt_use  = 1'b0;
      illegal = 1'b0;
      if (valid) begin
         unique case (opcode)
            OP_RTYPE: begin
               ctrl.reg_dst   = 1'b1;
               ctrl.alu_op    = ALU_FUNCT;
               ctrl.reg_write = 1'b1;
               wr_reg         = rd;
               rs_use         = 1'b1;
               rt_use         = 1'b1;
            end
            OP_LW: begin
               ctrl.alu_src    = 1'b1;
               ctrl.alu_op     = ALU_ADD;
               ctrl.mem_read   = 1'b1;
               ctrl.mem_to_reg = 1'b1;
               ctrl.reg_write  = 1'b1;
               wr_reg          = rt;
               rs_use          = 1'b1;
            end
            OP_SW: begin
               ctrl.alu_src   = 1'b1;
               ctrl.alu_op    = ALU_ADD;
               ctrl.mem_write = 1'b1;
               rs_use         = 1'b1;
               rt_use         = 1'b1;
            end
            OP_BEQ: begin
               ctrl.branch = 1'b1;
               ctrl.alu_op = ALU_SUB;
               rs_use      = 1'b1;
               rt_use      = 1'b1;
            end
            OP_J: begin
               ctrl.jump = 1'b1;
            end
            OP_JAL: begin
               ctrl.jump      = 1'b1;
               ctrl.reg_write = 1'b1;
               ctrl.link      = 1'b1;
               wr_reg         = REG_AW'(31);
            end
            OP_ADDI: begin
               ctrl.alu_src   = 1'b1;
               ctrl.alu_op    = ALU_ADD;
               ctrl.reg_write = 1'b1;
               wr_reg         = rt;
               rs_use         = 1'b1;
            end
            OP_ORI: begin
               ctrl.alu_src   = 1'b1;
               ctrl.alu_op    = ALU_OR;
               ctrl.reg_write = 1'b1;
               wr_reg         = rt;
               rs_use         = 1'b1;
            end
            default: illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decode, ID/EX -> EX/MEM -> MEM/WB control
// registers, load-use/branch/jump/freeze hazard control, illegal counter.
module pipe_ctrl_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW         = 5,
   parameter int CNT_W          = 8,
   parameter bit LOAD_USE_STALL = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [5:0]        id_opcode,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              ex_branch_taken,
   input  logic              stall_ext,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              ifid_flush,
   output logic              id_jump,
   output logic              ex_alu_src,
   output logic              ex_branch,
   output logic [1:0]        ex_alu_op,
   output logic [REG_AW-1:0] ex_wr_reg,
   output logic              mem_read,
   output logic              mem_write,
   output logic              wb_reg_write,
   output logic              wb_mem_to_reg,
   output logic              wb_link,
   output logic [REG_AW-1:0] wb_wr_reg,
   output logic              illegal_op,
   output logic [CNT_W-1:0]  illegal_cnt
);

   ctrl_t             dec_ctrl;
   logic [REG_AW-1:0] dec_wr_reg;
   logic              dec_rs_use;
   logic              dec_rt_use;
   logic              dec_illegal;

   ctrl_decode #(.REG_AW(REG_AW)) u_decode (
      .valid   (id_valid),
      .opcode  (id_opcode),
      .rt      (id_rt),
      .rd      (id_rd),
      .ctrl    (dec_ctrl),
      .wr_reg  (dec_wr_reg),
      .rs_use  (dec_rs_use),
      .rt_use  (dec_rt_use),
      .illegal (dec_illegal)
   );

   ctrl_t             idex;
   logic [REG_AW-1:0] idex_wr_reg;
   mem_ctrl_t         exmem;
   logic [REG_AW-1:0] exmem_wr_reg;
   wb_ctrl_t          memwb;
   logic [REG_AW-1:0] memwb_wr_reg;
   logic [CNT_W-1:0]  cnt;

   logic load_use;
   logic flush_br;
   logic idex_bubble;

   always_comb begin
      flush_br = idex.branch && ex_branch_taken;
      load_use = LOAD_USE_STALL && idex.mem_read && (idex_wr_reg != '0) &&
                 ((dec_rs_use && (idex_wr_reg == id_rs)) ||
                  (dec_rt_use && (idex_wr_reg == id_rt)));
      idex_bubble = flush_br || load_use;
   end

   // Hazard priority: reset, freeze, taken branch, load-use, normal.
   always_comb begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b0;
      id_jump    = 1'b0;
      illegal_op = 1'b0;
      if (rst) begin
         ifid_flush = 1'b1;
      end else if (stall_ext) begin
         pc_write = 1'b0;
      end else if (flush_br) begin
         pc_write   = 1'b1;
         ifid_write = 1'b1;
         ifid_flush = 1'b1;
      end else if (load_use) begin
         pc_write = 1'b0;
      end else begin
         pc_write   = 1'b1;
         ifid_write = 1'b1;
         ifid_flush = dec_ctrl.jump;
         id_jump    = dec_ctrl.jump;
         illegal_op = dec_illegal;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idex         <= CTRL_BUBBLE;
         idex_wr_reg  <= '0;
         exmem        <= MEM_BUBBLE;
         exmem_wr_reg <= '0;
         memwb        <= WB_BUBBLE;
         memwb_wr_reg <= '0;
      end else if (!stall_ext) begin
         idex         <= idex_bubble ? CTRL_BUBBLE : dec_ctrl;
         idex_wr_reg  <= idex_bubble ? '0 : dec_wr_reg;
         exmem        <= '{mem_read:   idex.mem_read,
                           mem_write:  idex.mem_write,
                           mem_to_reg: idex.mem_to_reg,
                           reg_write:  idex.reg_write,
                           link:       idex.link};
         exmem_wr_reg <= idex_wr_reg;
         memwb        <= '{mem_to_reg: exmem.mem_to_reg,
                           reg_write:  exmem.reg_write,
                           link:       exmem.link};
         memwb_wr_reg <= exmem_wr_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (illegal_op && (cnt != {CNT_W{1'b1}}))
         cnt <= cnt + 1'b1;
   end

   // reg_dst and jump are fully resolved in ID (wr_reg, id_jump).
   logic idex_unused;
   assign idex_unused = idex.reg_dst | idex.jump;

   assign ex_alu_src    = idex.alu_src;
   assign ex_branch     = idex.branch;
   assign ex_alu_op     = idex.alu_op;
   assign ex_wr_reg     = idex_wr_reg;
   assign mem_read      = exmem.mem_read;
   assign mem_write     = exmem.mem_write;
   assign wb_reg_write  = memwb.reg_write;
   assign wb_mem_to_reg = memwb.mem_to_reg;
   assign wb_link       = memwb.link;
   assign wb_wr_reg     = memwb_wr_reg;
   assign illegal_cnt   = cnt;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: default instance plus a CNT_W=2,
// no-interlock instance driven by the same stimulus.
module tb_pipe_ctrl_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [5:0] id_opcode;
   logic [4:0] id_rs, id_rt, id_rd;
   logic       ex_branch_taken;
   logic       stall_ext;

   logic       pc_write, ifid_write, ifid_flush, id_jump;
   logic       ex_alu_src, ex_branch;
   logic [1:0] ex_alu_op;
   logic [4:0] ex_wr_reg;
   logic       mem_read, mem_write;
   logic       wb_reg_write, wb_mem_to_reg, wb_link;
   logic [4:0] wb_wr_reg;
   logic       illegal_op;
   logic [7:0] illegal_cnt;

   logic       b_pc_write, b_ifid_write, b_ifid_flush, b_id_jump;
   logic       b_ex_alu_src, b_ex_branch;
   logic [1:0] b_ex_alu_op;
   logic [4:0] b_ex_wr_reg;
   logic       b_mem_read, b_mem_write;
   logic       b_wb_reg_write, b_wb_mem_to_reg, b_wb_link;
   logic [4:0] b_wb_wr_reg;
   logic       b_illegal_op;
   logic [1:0] b_illegal_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipe_ctrl_unit dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .ex_branch_taken(ex_branch_taken), .stall_ext(stall_ext),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .id_jump(id_jump), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
      .ex_alu_op(ex_alu_op), .ex_wr_reg(ex_wr_reg), .mem_read(mem_read),
      .mem_write(mem_write), .wb_reg_write(wb_reg_write),
      .wb_mem_to_reg(wb_mem_to_reg), .wb_link(wb_link), .wb_wr_reg(wb_wr_reg),
      .illegal_op(illegal_op), .illegal_cnt(illegal_cnt)
   );

   pipe_ctrl_unit #(.CNT_W(2), .LOAD_USE_STALL(1'b0)) dut2 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .ex_branch_taken(ex_branch_taken), .stall_ext(stall_ext),
      .pc_write(b_pc_write), .ifid_write(b_ifid_write), .ifid_flush(b_ifid_flush),
      .id_jump(b_id_jump), .ex_alu_src(b_ex_alu_src), .ex_branch(b_ex_branch),
      .ex_alu_op(b_ex_alu_op), .ex_wr_reg(b_ex_wr_reg), .mem_read(b_mem_read),
      .mem_write(b_mem_write), .wb_reg_write(b_wb_reg_write),
      .wb_mem_to_reg(b_wb_mem_to_reg), .wb_link(b_wb_link), .wb_wr_reg(b_wb_wr_reg),
      .illegal_op(b_illegal_op), .illegal_cnt(b_illegal_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd);
      id_valid  = v;
      id_opcode = op;
      id_rs     = rs;
      id_rt     = rt;
      id_rd     = rd;
      #1;
   endtask

   initial begin
      // reset, with an illegal opcode presented that must not be counted
      rst = 1'b1; ex_branch_taken = 1'b0; stall_ext = 1'b0;
      set_id(1'b1, 6'b111111, 5'd0, 5'd0, 5'd0);
      tick();
      chk("rst_ex", {ex_alu_src, ex_branch, ex_alu_op, ex_wr_reg}, 0);
      chk("rst_wb", {mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_link, wb_wr_reg}, 0);
      chk("rst_hz", {pc_write, ifid_write, ifid_flush, id_jump, illegal_op}, 5'b00100);
      chk("rst_cnt", illegal_cnt, 0);

      // load-use: lw $8 then add $9,$8,$2 (dependency on rt)
      rst = 1'b0;
      set_id(1'b1, 6'b100011, 5'd1, 5'd8, 5'd0);
      chk("lw_id_hz", {pc_write, ifid_write, ifid_flush, id_jump, illegal_op}, 5'b11000);
      tick();
      chk("lw_ex", {ex_alu_src, ex_alu_op, ex_wr_reg}, {1'b1, 2'b00, 5'd8});
      set_id(1'b1, 6'b000000, 5'd2, 5'd8, 5'd9);
      chk("lu_stall", {pc_write, ifid_write, ifid_flush}, 3'b000);
      chk("lu_nostall", {b_pc_write, b_ifid_write}, 2'b11);
      tick();
      chk("lu_bubble", {ex_alu_src, ex_alu_op, ex_wr_reg}, 0);
      chk("lu_mem", mem_read, 1);
      chk("lu_nostall_ex", {b_ex_alu_op, b_ex_wr_reg}, {2'b10, 5'd9});
      chk("lu_release", {pc_write, ifid_write}, 2'b11);
      tick();
      chk("add_ex_late", {ex_alu_op, ex_wr_reg}, {2'b10, 5'd9});
      chk("lw_wb", {wb_reg_write, wb_mem_to_reg, wb_link, wb_wr_reg}, {3'b110, 5'd8});
      chk("bub_mem", mem_read, 0);

      // taken beq; jal sitting in ID behind it is squashed
      set_id(1'b1, 6'b000100, 5'd3, 5'd4, 5'd0);
      tick();
      chk("beq_ex", {ex_branch, ex_alu_op, ex_wr_reg}, {1'b1, 2'b01, 5'd0});
      ex_branch_taken = 1'b1;
      set_id(1'b1, 6'b000011, 5'd0, 5'd0, 5'd0);
      chk("br_flush", {pc_write, ifid_flush, id_jump}, 3'b110);
      tick();
      ex_branch_taken = 1'b0;
      chk("br_bubble", {ex_branch, ex_wr_reg}, 0);
      set_id(1'b0, 6'b000000, 5'd0, 5'd0, 5'd0);
      tick();

      // jal: one-cycle redirect, link write three cycles later
      set_id(1'b1, 6'b000011, 5'd0, 5'd0, 5'd0);
      chk("jal_hz", {pc_write, ifid_flush, id_jump}, 3'b111);
      tick();
      chk("jal_ex", ex_wr_reg, 31);
      chk("sq1_wb", wb_reg_write, 0);
      set_id(1'b0, 6'b000000, 5'd0, 5'd0, 5'd0);
      chk("jal_once", {id_jump, ifid_flush}, 2'b00);
      tick();
      chk("sq2_wb", wb_reg_write, 0);
      tick();
      chk("jal_wb", {wb_reg_write, wb_link, wb_mem_to_reg, wb_wr_reg}, {3'b110, 5'd31});

      // five illegal opcodes: 8-bit counter reaches 5, 2-bit saturates at 3
      set_id(1'b1, 6'b111111, 5'd1, 5'd2, 5'd3);
      chk("ill_op", {illegal_op, b_illegal_op}, 2'b11);
      for (int i = 0; i < 5; i++) tick();
      chk("ill_cnt8", illegal_cnt, 5);
      chk("ill_cnt2", b_illegal_cnt, 3);
      chk("ill_sat_pulse", b_illegal_op, 1);
      chk("ill_ex", {ex_alu_src, ex_branch, ex_alu_op, ex_wr_reg}, 0);
      chk("ill_wb", {mem_read, mem_write, wb_reg_write, wb_link, wb_wr_reg}, 0);

      // stall_ext for 3 cycles mid-stream: addi, ori, sw
      set_id(1'b1, 6'b001000, 5'd1, 5'd11, 5'd0);
      tick();
      set_id(1'b1, 6'b001101, 5'd1, 5'd12, 5'd0);
      tick();
      stall_ext = 1'b1;
      set_id(1'b1, 6'b101011, 5'd1, 5'd13, 5'd0);
      chk("frz_hz", {pc_write, ifid_write, ifid_flush, id_jump}, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("frz_ex", {ex_alu_src, ex_alu_op, ex_wr_reg}, {1'b1, 2'b11, 5'd12});
         chk("frz_wb", {wb_reg_write, wb_wr_reg, pc_write}, 0);
      end
      stall_ext = 1'b0;
      #1;
      tick();
      chk("res_ex", {ex_alu_src, ex_alu_op, ex_wr_reg}, {1'b1, 2'b00, 5'd0});
      chk("res_wb", {wb_reg_write, wb_wr_reg}, {1'b1, 5'd11});
      set_id(1'b0, 6'b000000, 5'd0, 5'd0, 5'd0);
      tick();
      chk("res_mem", {mem_write, mem_read}, 2'b10);
      chk("res_wb2", {wb_reg_write, wb_wr_reg}, {1'b1, 5'd12});

      // freeze during load-use: freeze wins, then stall re-evaluated
      set_id(1'b1, 6'b100011, 5'd1, 5'd14, 5'd0);
      tick();
      stall_ext = 1'b1;
      set_id(1'b1, 6'b101011, 5'd14, 5'd5, 5'd0);
      chk("frz_lu_hz", {pc_write, ifid_write, ifid_flush}, 0);
      tick();
      chk("frz_lu_hold", ex_wr_reg, 14);
      stall_ext = 1'b0;
      #1;
      chk("lu_after_frz", {pc_write, ifid_write}, 2'b00);
      tick();
      chk("lu_after_bub", {ex_wr_reg, ex_alu_src}, 0);
      chk("lu_after_rel", pc_write, 1);

      // reset with lw in MEM and jal in EX
      set_id(1'b1, 6'b100011, 5'd1, 5'd15, 5'd0);
      tick();
      set_id(1'b1, 6'b000010 | 6'b000001, 5'd0, 5'd0, 5'd0);
      chk("jal2_hz", id_jump, 1);
      tick();
      chk("pre_rst", {mem_read, ex_wr_reg}, {1'b1, 5'd31});
      rst = 1'b1;
      set_id(1'b0, 6'b000000, 5'd0, 5'd0, 5'd0);
      chk("rst2_hz", {pc_write, ifid_write, ifid_flush, id_jump}, 4'b0010);
      tick();
      chk("rst2_ex", {ex_alu_src, ex_branch, ex_alu_op, ex_wr_reg}, 0);
      chk("rst2_wb", {mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_link, wb_wr_reg}, 0);
      chk("rst2_cnt", {illegal_cnt, b_illegal_cnt}, 0);
      rst = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
